// File: rtl/crc_stream_engine_if.sv
// Handshake bundle between a word source and crc_stream_engine.
// CRC_STREAM_CHK_EN adds the expected-CRC input and the mismatch flag.
interface crc_stream_engine_if #(
  parameter int DATA_W = 16,
  parameter int CRC_W  = 8
);
  logic              in_vld;
  logic              in_rdy;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              crc_vld;
  logic [CRC_W-1:0]  crc_out;
  logic              busy;
`ifdef CRC_STREAM_CHK_EN
  logic [CRC_W-1:0]  crc_exp;
  logic              crc_err;

  modport master (
    output in_vld, in_data, in_last, crc_exp,
    input  in_rdy, crc_vld, crc_out, busy, crc_err
  );
  modport slave (
    input  in_vld, in_data, in_last, crc_exp,
    output in_rdy, crc_vld, crc_out, busy, crc_err
  );
`else
  modport master (
    output in_vld, in_data, in_last,
    input  in_rdy, crc_vld, crc_out, busy
  );
  modport slave (
    input  in_vld, in_data, in_last,
    output in_rdy, crc_vld, crc_out, busy
  );
`endif
endinterface

// File: rtl/crc_stream_engine.sv
// Streamed CRC engine folding CHUNK_W message bits per clock, MSB first.
// Define CRC_STREAM_CHK_EN to add the crc_exp compare and the crc_err flag.
//
// state   | meaning
// ST_IDLE | ready; an accepted word's top chunk folds on the accept edge
// ST_RUN  | folding the remaining chunks of the held word, in_rdy low
module crc_stream_engine #(
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = 8'h2F,
  parameter logic [CRC_W-1:0] INIT    = 8'hFF,
  parameter int               DATA_W  = 16,
  parameter int               CHUNK_W = 16
) (
  input logic             clk_i,
  input logic             rst_n_i,
  input logic             clr_i,
  crc_stream_engine_if.slave bus
);
  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  typedef enum logic {ST_IDLE, ST_RUN} st_t;

  st_t               st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [CRC_W-1:0]  crc_out_q, crc_out_d;
  logic              crc_vld_q, crc_vld_d;
  logic              busy_q, busy_d;
`ifdef CRC_STREAM_CHK_EN
  logic [CRC_W-1:0]  exp_q, exp_d;
  logic              err_q, err_d;
`endif

  logic              rdy, accept, step, final_chunk, fin_last;
  logic [CHUNK_W-1:0] chunk;
  logic [CRC_W-1:0]  folded;

  function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] crc,
                                            input logic [CHUNK_W-1:0] bits);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc;
    for (int i = CHUNK_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ bits[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) st_q <= ST_IDLE;
    else          st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (clr_i) begin
      st_d = ST_IDLE;
    end else begin
      case (st_q)
        ST_IDLE: if (accept && NCHUNK > 1) st_d = ST_RUN;
        ST_RUN:  if (cnt_q == CNT_W'(1))   st_d = ST_IDLE;
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rdy          = (st_q == ST_IDLE);
    bus.in_rdy   = rdy;
    bus.crc_vld  = crc_vld_q;
    bus.crc_out  = crc_out_q;
    bus.busy     = busy_q;
`ifdef CRC_STREAM_CHK_EN
    bus.crc_err  = err_q;
`endif
  end

  assign accept      = bus.in_vld && rdy;
  assign step        = accept || (st_q == ST_RUN);
  assign chunk       = rdy ? bus.in_data[DATA_W-1 -: CHUNK_W] : data_q[DATA_W-1 -: CHUNK_W];
  assign folded      = fold(crc_q, chunk);
  assign final_chunk = rdy ? (NCHUNK == 1) : (cnt_q == CNT_W'(1));
  assign fin_last    = rdy ? bus.in_last : last_q;

  always_comb begin
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    last_d    = last_q;
    crc_out_d = crc_out_q;
    crc_vld_d = 1'b0;
    busy_d    = busy_q;
`ifdef CRC_STREAM_CHK_EN
    exp_d     = exp_q;
    err_d     = err_q;
`endif
    if (clr_i) begin
      // abort wins even over a completing chunk: no strobe, crc_out kept
      crc_d  = INIT;
      cnt_d  = '0;
      busy_d = 1'b0;
`ifdef CRC_STREAM_CHK_EN
      err_d  = 1'b0;
`endif
    end else if (step) begin
      if (rdy) begin
        data_d = bus.in_data << CHUNK_W;
        last_d = bus.in_last;
        cnt_d  = CNT_LAST;
`ifdef CRC_STREAM_CHK_EN
        exp_d  = bus.crc_exp;
`endif
      end else begin
        data_d = data_q << CHUNK_W;
        cnt_d  = cnt_q - CNT_W'(1);
      end
      if (final_chunk && fin_last) begin
        crc_out_d = folded;
        crc_vld_d = 1'b1;
        crc_d     = INIT;
        busy_d    = 1'b0;
`ifdef CRC_STREAM_CHK_EN
        err_d     = (folded != (rdy ? bus.crc_exp : exp_q));
`endif
      end else begin
        crc_d  = folded;
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      crc_q     <= INIT;
      data_q    <= '0;
      last_q    <= 1'b0;
      crc_out_q <= '0;
      crc_vld_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef CRC_STREAM_CHK_EN
      exp_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      data_q    <= data_d;
      last_q    <= last_d;
      crc_out_q <= crc_out_d;
      crc_vld_q <= crc_vld_d;
      busy_q    <= busy_d;
`ifdef CRC_STREAM_CHK_EN
      exp_q     <= exp_d;
      err_q     <= err_d;
`endif
    end
  end
endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
- Sequential, parametrised CRC engine for streamed multi-word messages. Next generation of the fixed 16-bit-data / CRC-8 combinational generator.
- Accepts DATA_W-bit words over a valid/ready handshake and folds CHUNK_W bits per clock into a running CRC register.
- On the word flagged last, publishes the final CRC with a one-cycle valid strobe.
- Sits between the frame packer/unpacker and the link layer for both TX generation and RX checking.

Parameters:
- CRC_W, 8: CRC register width.
- POLY, 8'h2F: generator polynomial, x^CRC_W term implied; default = 1+x+x^2+x^3+x^5+x^8.
- INIT, 8'hFF: CRC register value at reset, after clr, and after every completed message.
- DATA_W, 16: input word width; must be an integer multiple of CHUNK_W.
- CHUNK_W, 16: bits folded per clock. NCHUNK = DATA_W/CHUNK_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort: drop the message in progress and reload INIT
- in_vld  in  1  input word valid
- in_rdy  out  1  engine can accept a word
- in_data  in  DATA_W  message word, MSB transmitted first
- in_last  in  1  word is the final word of the message
- crc_vld  out  1  one-cycle strobe: crc_out updated
- crc_out  out  CRC_W  final CRC of the last message; held until the next crc_vld
- busy  out  1  message in progress: at least one word accepted, last not yet completed

Behaviour:
- Reset and clock: rst_n is asynchronous and active-low; clk is the single clock.
- Reset values: crc_reg=INIT, crc_out=0, crc_vld=0, state=ST_IDLE, in_rdy=1, busy=0, chunk counter=0.
- Bit update, per data bit b, MSB of in_data first: fb = crc[CRC_W-1]^b; crc = {crc[CRC_W-2:0],0} ^ (fb ? POLY : 0).
  - Each chunk applies CHUNK_W of these steps combinationally.
  - No reflection, no final XOR.
- ST_IDLE (in_rdy=1):
  - On in_vld&in_rdy, the top chunk of in_data is folded at that edge.
  - The remaining chunks, in_data, and in_last are registered.
  - If NCHUNK>1, go to ST_RUN; otherwise stay in ST_IDLE (full throughput, one word per clock).
- ST_RUN (in_rdy=0): one chunk per clock, MSB-down. After the final chunk, return to ST_IDLE. Word cost = NCHUNK clocks.
- Completion:
  - At the edge folding the final chunk of a word with in_last=1: crc_out <= folded value, crc_vld=1 for the next cycle only, crc_reg <= INIT.
  - Latency from accept edge to crc_vld high: NCHUNK cycles.
- Back-to-back: a new message may be accepted in the cycle crc_vld is high. It starts from INIT.
- busy: set on the first accepted word of a message; cleared on the completion edge. A single-word last message never raises busy when NCHUNK=1.
- clr:
  - Has priority over everything: crc_reg=INIT, state=ST_IDLE, counter=0.
  - No crc_vld, including when it coincides with a final chunk; any word accepted in the same cycle is discarded.
  - crc_out is retained.
- rst_n asserted mid-message: everything returns to reset values immediately; the partial message is lost.
- in_data is sampled only on the accept edge; it may change while in ST_RUN.

Optional Feature:
- Macro: CRC_STREAM_CHK_EN.
- When defined:
  - Adds port crc_exp (in, CRC_W), sampled with the last word.
  - Adds port crc_err (out, 1), registered alongside crc_out: crc_err = (folded CRC != crc_exp), valid while crc_vld=1 and held afterwards. Reset value 0.
  - clr clears crc_err.
- When undefined: neither port exists; no compare logic is instantiated.

Test Plan:
- Defaults, single word in_data=16'h0000 with last=1 → crc_vld high one cycle after accept, crc_out=8'hB8, in_rdy stays 1.
- Defaults, 16'h0000 then 16'h0000 back-to-back, second with last → one crc_vld only, after the second word; crc_out equals bit-serial model over 32 zero bits; a third word accepted during crc_vld starts from 8'hFF.
- CHUNK_W=4, DATA_W=16, in_data=16'h0000 last → in_rdy low for 3 cycles, crc_vld 4 cycles after accept, crc_out=8'hB8 (chunking-invariant).
- clr asserted in the same cycle as the final chunk of a last word → no crc_vld, crc_out keeps previous value; next message computed from INIT.
- rst_n pulsed low mid-ST_RUN → outputs at reset values asynchronously; a fresh message after release gives correct CRC.
- CRC_STREAM_CHK_EN: message 16'h0000 with crc_exp=8'hB8 → crc_err=0; crc_exp=8'hB9 → crc_err=1; randomised lengths checked against a software model.
